uart_mmio_bridge: RTL

//  Data-side bus stage between the pipeline CPU's memory port and data RAM.

---
 rtl/uart_mmio_bridge.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio_bridge.sv
// Data-side bus stage: routes CPU accesses either to data RAM or to a memory-mapped
// 8N1 UART transmitter with a TX FIFO, and muxes load data back to the CPU.
module uart_mmio_bridge #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_F000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    output logic [31:0] cpu_rdata,
    output logic        ram_we,
    input  logic [31:0] ram_rdata,
    output logic        uart_tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] ONE_C   = (PW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic          sel_s, wr_s, push_req_s, push_ok_s, pop_s;
    logic [1:0]    off_s;
    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [PW:0]   count_r;
    logic          ovf_r;
    logic [15:0]   div_r;
    state_t        state_r, state_next_s;
    logic [15:0]   cnt_r, cnt_next_s, bit_div_r, bit_div_next_s;
    logic [2:0]    idx_r, idx_next_s;
    logic [7:0]    shift_r, shift_next_s;
    logic          bit_end_s, tx_s, busy_s, tx_r;
    logic          empty_s, full_s, done_s;
    logic [31:0]   reg_rd_s;
    logic          unused_bits_s;

    assign sel_s      = (cpu_addr[31:12] == BASE_ADDR[31:12]);
    assign off_s      = cpu_addr[3:2];
    assign wr_s       = cpu_we & sel_s;
    assign push_req_s = wr_s & (off_s == 2'd0);
    assign pop_s      = (state_r == ST_IDLE) & (count_r != {(PW+1){1'b0}});
    // A full FIFO still accepts a push when the transmitter drains an entry that same cycle.
    assign push_ok_s  = push_req_s & ((count_r < DEPTH_C) | pop_s);
    assign empty_s    = (count_r == {(PW+1){1'b0}});
    assign full_s     = (count_r == DEPTH_C);
    assign done_s     = empty_s & (state_r == ST_IDLE);

    assign ram_we        = cpu_we & ~sel_s;
    assign cpu_rdata     = sel_s ? reg_rd_s : ram_rdata;
    assign uart_tx       = tx_r;
    assign unused_bits_s = ^{cpu_addr[11:4], cpu_addr[1:0], cpu_wdata[31:16]};

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) fifo_mem_r[wr_ptr_r] <= cpu_wdata[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            if (pop_s)     rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
            if (push_req_s && !push_ok_s)                      ovf_r <= 1'b1;
            else if (wr_s && off_s == 2'd1 && cpu_wdata[3])    ovf_r <= 1'b0;
            else                                               ovf_r <= ovf_r;
        end
    end

    // Baud divisor register, clamped to a minimum of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= DEFAULT_DIV;
        end else if (wr_s && off_s == 2'd2) begin
            div_r <= (cpu_wdata[15:0] < 16'd2) ? 16'd2 : cpu_wdata[15:0];
        end else begin
            div_r <= div_r;
        end
    end

    // Transmitter state register and registered serial output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            bit_div_r <= 16'd2;
            idx_r     <= 3'd0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            bit_div_r <= bit_div_next_s;
            idx_r     <= idx_next_s;
            shift_r   <= shift_next_s;
            tx_r      <= tx_s;
        end
    end

    // Next-state logic; the divisor is latched per bit so a mid-frame change lands on a boundary.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r + 16'd1;
        bit_div_next_s = bit_div_r;
        idx_next_s     = idx_r;
        shift_next_s   = shift_r;
        bit_end_s      = (cnt_r == bit_div_r - 16'd1);
        case (state_r)
            ST_IDLE: begin
                cnt_next_s = 16'd0;
                if (pop_s) begin
                    state_next_s   = ST_START;
                    shift_next_s   = fifo_mem_r[rd_ptr_r];
                    bit_div_next_s = div_r;
                end else begin
                    state_next_s   = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_next_s   = ST_DATA;
                    cnt_next_s     = 16'd0;
                    idx_next_s     = 3'd0;
                    bit_div_next_s = div_r;
                end else begin
                    state_next_s   = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_next_s     = 16'd0;
                    shift_next_s   = {1'b0, shift_r[7:1]};
                    bit_div_next_s = div_r;
                    idx_next_s     = idx_r + 3'd1;
                    state_next_s   = (idx_r == 3'd7) ? ST_STOP : ST_DATA;
                end else begin
                    state_next_s   = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 16'd0;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 16'd0;
            end
        endcase
    end

    // Output decode: line level and busy flag per state.
    always_comb begin
        tx_s   = 1'b1;
        busy_s = 1'b0;
        case (state_r)
            ST_IDLE:  begin tx_s = 1'b1;       busy_s = 1'b0; end
            ST_START: begin tx_s = 1'b0;       busy_s = 1'b1; end
            ST_DATA:  begin tx_s = shift_r[0]; busy_s = 1'b1; end
            ST_STOP:  begin tx_s = 1'b1;       busy_s = 1'b1; end
            default:  begin tx_s = 1'b1;       busy_s = 1'b0; end
        endcase
    end

    // Register read mux for the UART window.
    always_comb begin
        reg_rd_s = 32'd0;
        case (off_s)
            2'd1:    reg_rd_s = {26'd0, 1'b0, done_s, ovf_r, busy_s, empty_s, full_s};
            2'd2:    reg_rd_s = {16'd0, div_r};
            default: reg_rd_s = 32'd0;
        endcase
    end
endmodule
